euler_writeback_stage: RTL and testbench

Write-back end of the Euler pipeline: accepts finished row results (one per matrix row) from the accumulator over a valid/ready handshake, narrows each to DATA_SIZE, and writes it to result memory at consecutive addresses from a base. It is the memory-writing counterpart of fetch_stage, shares the single memory port with it through a request/grant pair, and pulses final_done once all rows of the step are written.

---
 rtl/euler_writeback_stage.sv | 102 ++++++++++
 tb/tb_euler_writeback_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/euler_writeback_stage.sv
// euler_writeback_stage: writes narrowed row results to memory at base+index via request/grant.
// Define WB_SATURATE_EN to saturate out-of-range results instead of wrapping.
module euler_writeback_stage #(
   parameter int ADD_SIZE  = 16,
   parameter int DATA_SIZE = 16,
   parameter int GUARD     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       init_start,
   input  logic [ADD_SIZE-1:0]        base_addr,
   input  logic [ADD_SIZE-1:0]        row_count,
   input  logic                       result_valid,
   input  logic [DATA_SIZE+GUARD-1:0] result_data,
   output logic                       result_ready,
   output logic                       mem_wr_req,
   input  logic                       mem_grant,
   output logic [ADD_SIZE-1:0]        mem_addr,
   output logic [DATA_SIZE-1:0]       mem_wr_data,
   output logic                       row_written,
   output logic                       busy,
   output logic                       final_done
);
   localparam int RW = DATA_SIZE + GUARD;
   typedef enum logic [1:0] {IDLE, WAIT_RES, WRITE, DONE} state_t;
   state_t state;
   logic [ADD_SIZE-1:0] base_q, count_q, idx;
   logic [DATA_SIZE-1:0] narrowed;
`ifdef WB_SATURATE_EN
   localparam logic signed [RW-1:0] MAX_V = $signed({{(GUARD+1){1'b0}}, {(DATA_SIZE-1){1'b1}}});
   localparam logic signed [RW-1:0] MIN_V = $signed({{(GUARD+1){1'b1}}, {(DATA_SIZE-1){1'b0}}});
   always_comb
      narrowed = ($signed(result_data) > MAX_V) ? {1'b0, {(DATA_SIZE-1){1'b1}}} :
                 ($signed(result_data) < MIN_V) ? {1'b1, {(DATA_SIZE-1){1'b0}}} :
                 result_data[DATA_SIZE-1:0];
`else
   logic unused_guard;
   assign unused_guard = ^result_data[RW-1:DATA_SIZE];
   assign narrowed = result_data[DATA_SIZE-1:0];
`endif
   // mem_wr_data doubles as the hold register; it is only meaningful while mem_wr_req is high
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         base_q       <= '0;
         count_q      <= '0;
         idx          <= '0;
         result_ready <= 1'b0;
         mem_wr_req   <= 1'b0;
         mem_addr     <= '0;
         mem_wr_data  <= '0;
         row_written  <= 1'b0;
         busy         <= 1'b0;
         final_done   <= 1'b0;
      end else begin
         row_written <= 1'b0;
         final_done  <= 1'b0;
         if (init_start) begin
            base_q     <= base_addr;
            count_q    <= row_count;
            idx        <= '0;
            mem_wr_req <= 1'b0;
            busy       <= 1'b1;
            if (row_count == '0) begin
               state        <= DONE;
               result_ready <= 1'b0;
               final_done   <= 1'b1;
            end else begin
               state        <= WAIT_RES;
               result_ready <= 1'b1;
            end
         end else begin
            case (state)
               WAIT_RES: if (result_valid) begin
                  mem_wr_data  <= narrowed;
                  mem_addr     <= base_q + idx;
                  result_ready <= 1'b0;
                  mem_wr_req   <= 1'b1;
                  state        <= WRITE;
               end
               WRITE: if (mem_grant) begin
                  mem_wr_req  <= 1'b0;
                  row_written <= 1'b1;
                  idx         <= idx + 1'b1;
                  if (idx == count_q - 1'b1) begin
                     state      <= DONE;
                     final_done <= 1'b1;
                  end else begin
                     state        <= WAIT_RES;
                     result_ready <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_euler_writeback_stage.sv
// tb_euler_writeback_stage: directed scoreboard bench for euler_writeback_stage.
module tb_euler_writeback_stage;
   logic clk = 0, rst = 1, init_start = 0, result_valid = 0, mem_grant = 0;
   logic [15:0] base_addr = 0, row_count = 0;
   logic [19:0] result_data = 0;
   logic result_ready, mem_wr_req, row_written, busy, final_done;
   logic [15:0] mem_addr, mem_wr_data;
   int checks = 0, failures = 0;
   logic [31:0] sb[$];
   euler_writeback_stage dut (
      .clk(clk), .rst(rst), .init_start(init_start), .base_addr(base_addr),
      .row_count(row_count), .result_valid(result_valid), .result_data(result_data),
      .result_ready(result_ready), .mem_wr_req(mem_wr_req), .mem_grant(mem_grant),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .row_written(row_written),
      .busy(busy), .final_done(final_done)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [15:0] narrow(input logic [19:0] d);
`ifdef WB_SATURATE_EN
      if ($signed(d) > 20'sd32767) return 16'h7FFF;
      if ($signed(d) < -20'sd32768) return 16'h8000;
`endif
      return d[15:0];
   endfunction
   task automatic start(input logic [15:0] b, input logic [15:0] c);
      init_start = 1; base_addr = b; row_count = c;
      tick();
      init_start = 0;
   endtask
   task automatic row(input logic [19:0] d, input int gdelay, input logic [15:0] addr);
      logic [31:0] e;
      chk("ready_before_accept", result_ready, 1);
      result_valid = 1; result_data = d;
      sb.push_back({addr, narrow(d)});
      tick();
      result_valid = 0;
      chk("req_after_accept", mem_wr_req, 1);
      chk("ready_low_in_write", result_ready, 0);
      chk("no_row_written_in_write", row_written, 0);
      for (int i = 0; i < gdelay; i++) begin
         chk("req_held", mem_wr_req, 1);
         chk("addr_held", mem_addr, addr);
         chk("data_held", mem_wr_data, narrow(d));
         chk("ready_held_low", result_ready, 0);
         tick();
      end
      mem_grant = 1;
      e = sb.pop_front();
      chk("wr_addr", mem_addr, e[31:16]);
      chk("wr_data", mem_wr_data, e[15:0]);
      tick();
      mem_grant = 0;
      chk("row_written", row_written, 1);
      chk("req_dropped", mem_wr_req, 0);
   endtask
   task automatic finish_check();
      chk("final_done_pulse", final_done, 1);
      chk("busy_in_done", busy, 1);
      tick();
      chk("final_done_single", final_done, 0);
      chk("busy_low", busy, 0);
   endtask
   initial begin
      tick(); tick();
      chk("rst_ready", result_ready, 0);
      chk("rst_req", mem_wr_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_wr_data, 0);
      chk("rst_row_written", row_written, 0);
      chk("rst_busy", busy, 0);
      chk("rst_final_done", final_done, 0);
      rst = 0;
      tick();
      chk("idle_ready", result_ready, 0);
      start(16'h0100, 3);
      chk("busy_started", busy, 1);
      row(20'd5, 0, 16'h0100);
      row(20'hFFFFE, 0, 16'h0101);
      chk("not_done_early", final_done, 0);
      row(20'd7, 0, 16'h0102);
      finish_check();
      start(16'h0100, 3);
      row(20'd5, 0, 16'h0100);
      row(20'hFFFFE, 4, 16'h0101);
      row(20'd7, 0, 16'h0102);
      finish_check();
      start(16'h0000, 0);
      chk("zero_req", mem_wr_req, 0);
      chk("zero_ready", result_ready, 0);
      finish_check();
      start(16'hFFFF, 2);
      row(20'd1, 0, 16'hFFFF);
      row(20'd2, 1, 16'h0000);
      finish_check();
      start(16'h0010, 2);
      row(20'h12345, 0, 16'h0010);
      row(20'hF0000, 0, 16'h0011);
      finish_check();
      start(16'h0200, 3);
      row(20'd9, 0, 16'h0200);
      result_valid = 1; result_data = 20'd11;
      tick();
      result_valid = 0;
      chk("abort_req_before_rst", mem_wr_req, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("rst_mid_req", mem_wr_req, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_addr", mem_addr, 0);
      chk("rst_mid_data", mem_wr_data, 0);
      chk("rst_mid_ready", result_ready, 0);
      start(16'h0300, 2);
      result_valid = 1; result_data = 20'd3;
      tick();
      result_valid = 0;
      chk("abort_req_before_init", mem_wr_req, 1);
      start(16'h0400, 1);
      chk("init_mid_req", mem_wr_req, 0);
      chk("init_mid_busy", busy, 1);
      row(20'd42, 0, 16'h0400);
      finish_check();
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
